// File: rtl/zpu_io_pkg.sv
// Shared constants and types for the ZPU memory/IO bridge.
// IO register offsets are keyed on mem_addr[3:2] inside the IO window.
package zpu_io_pkg;

  localparam logic [1:0] IO_LED         = 2'd0;
  localparam logic [1:0] IO_UART_DATA   = 2'd1;
  localparam logic [1:0] IO_UART_STATUS = 2'd2;

  localparam int STAT_FIFO_FULL  = 0;
  localparam int STAT_FIFO_EMPTY = 1;
  localparam int STAT_TX_BUSY    = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RAM_WAIT = 2'd1,
    ST_IO_WAIT  = 2'd2,
    ST_DONE     = 2'd3
  } bridge_state_e;

  function automatic logic [31:0] status_word(input logic full, input logic empty,
                                              input logic busy);
    logic [31:0] w;
    w                  = '0;
    w[STAT_FIFO_FULL]  = full;
    w[STAT_FIFO_EMPTY] = empty;
    w[STAT_TX_BUSY]    = busy;
    return w;
  endfunction

endpackage

// File: rtl/zpu_io_bridge_uart_tx.sv
// Buffered 8N1 transmitter: a small byte FIFO feeding a start/data/stop shifter.
// The next frame is loaded in the stop bit's last clock so queued bytes go out gap-free.
module zpu_uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  logic [7:0] data_i,
  output logic       full_o,
  output logic       empty_o,
  output logic       busy_o,
  output logic       tx_o
);
  import zpu_io_pkg::*;

  localparam int IDX_W  = $clog2(FIFO_DEPTH);
  localparam int PTR_W  = IDX_W + 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        BIT_LAST  = 4'd9;

  logic [7:0]        fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [9:0]        shift_q, shift_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic              busy_q, busy_d;
  logic              full, empty, frame_end, pop, push_ok;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                     (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign frame_end = busy_q && (baud_q == BAUD_LAST) && (bit_cnt_q == BIT_LAST);
  assign pop       = !empty && (!busy_q || frame_end);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_ok   = push_i && (!full || pop);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    baud_d    = baud_q;
    busy_d    = busy_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      shift_d   = {1'b1, fifo_q[rd_ptr_q[IDX_W-1:0]], 1'b0};
      bit_cnt_d = 4'd0;
      baud_d    = '0;
      busy_d    = 1'b1;
    end else if (busy_q) begin
      if (baud_q == BAUD_LAST) begin
        baud_d = '0;
        if (bit_cnt_q == BIT_LAST) begin
          busy_d = 1'b0;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          shift_d   = {1'b1, shift_q[9:1]};
        end
      end else begin
        baud_d = baud_q + BAUD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      shift_q   <= '1;
      bit_cnt_q <= 4'd0;
      baud_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      baud_q    <= baud_d;
      busy_q    <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr_q[IDX_W-1:0]] <= data_i;
  end

  assign full_o  = full;
  assign empty_o = empty;
  assign busy_o  = busy_q;
  assign tx_o    = busy_q ? shift_q[0] : 1'b1;

endmodule

// File: rtl/zpu_io_bridge.sv
// Bridge between the ZPU data port, the 1-cycle internal RAM, an LED register
// and a buffered UART transmitter. Handshake: the core holds mem_read/mem_write
// with a stable address until a single-cycle mem_done; the request must drop
// before another access is accepted.
module zpu_io_bridge #(
  parameter int ADDR_WIDTH     = 16,
  parameter int RAM_ADDR_WIDTH = 10,
  parameter int CLKS_PER_BIT   = 104,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mem_read,
  input  logic                      mem_write,
  input  logic [ADDR_WIDTH-1:0]     mem_addr,
  input  logic [31:0]               mem_data_write,
  output logic [31:0]               mem_data_read,
  output logic                      mem_done,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic                      ram_write_en,
  output logic [31:0]               ram_din,
  input  logic [31:0]               ram_dout,
  output logic [4:0]                leds,
  output logic                      uart_tx,
  output logic [1:0]                dbg_state_o
);
  import zpu_io_pkg::*;

  bridge_state_e state_q, state_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [4:0]    leds_q, leds_d;
  logic          hold_q, hold_d;
  logic          req, is_wr, is_io;
  logic [1:0]    io_sel;
  logic          uart_push, uart_full, uart_empty, uart_busy;
  logic          unused_addr_bits;

  assign req              = mem_read | mem_write;
  assign is_wr            = mem_write;
  assign is_io            = mem_addr[ADDR_WIDTH-1];
  assign io_sel           = mem_addr[3:2];
  assign unused_addr_bits = ^mem_addr;

  always_comb begin
    state_d      = state_q;
    rdata_d      = rdata_q;
    leds_d       = leds_q;
    hold_d       = req ? hold_q : 1'b0;
    uart_push    = 1'b0;
    ram_write_en = 1'b0;
    mem_done     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // hold_q blocks a request still held over from the previous access.
        if (req && !hold_q) state_d = is_io ? ST_IO_WAIT : ST_RAM_WAIT;
      end
      ST_RAM_WAIT: begin
        ram_write_en = is_wr;
        if (!is_wr) rdata_d = ram_dout;
        state_d = ST_DONE;
      end
      ST_IO_WAIT: begin
        state_d = ST_DONE;
        if (is_wr) begin
          case (io_sel)
            IO_LED: leds_d = mem_data_write[4:0];
            IO_UART_DATA: begin
              if (uart_full) state_d = ST_IO_WAIT;
              else           uart_push = 1'b1;
            end
            default: ;
          endcase
        end else begin
          case (io_sel)
            IO_LED:         rdata_d = {27'd0, leds_q};
            IO_UART_STATUS: rdata_d = status_word(uart_full, uart_empty, uart_busy);
            default:        rdata_d = '0;
          endcase
        end
      end
      ST_DONE: begin
        mem_done = 1'b1;
        hold_d   = req;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
      leds_q  <= '0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      leds_q  <= leds_d;
      hold_q  <= hold_d;
    end
  end

  zpu_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) u_uart_tx (
    .clk    (clk),
    .reset  (reset),
    .push_i (uart_push),
    .data_i (mem_data_write[7:0]),
    .full_o (uart_full),
    .empty_o(uart_empty),
    .busy_o (uart_busy),
    .tx_o   (uart_tx)
  );

  assign mem_data_read = rdata_q;
  assign ram_addr      = mem_addr[RAM_ADDR_WIDTH-1:0];
  assign ram_din       = mem_data_write;
  assign leds          = leds_q;
  assign dbg_state_o   = state_q;

endmodule
